// File: rtl/hazard_defs_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects and FSM states.
package hazard_defs;
    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;
endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Per-operand forwarding select for the EX-stage ALU; combinational, MEM beats WB, $zero never forwarded.
module fwd_select
    import hazard_defs::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    output logic [1:0]        sel
);
    always_comb begin
        sel = FWD_REG;
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == src)) begin
            sel = FWD_MEM;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == src)) begin
            sel = FWD_WB;
        end
    end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/branch controller for a 5-stage pipeline: operand forwarding, load-use stalls,
// taken-branch redirect and squash, plus saturating stall/flush counters.
module pipeline_hazard_ctrl
    import hazard_defs::*;
#(
    parameter int REG_AW     = 5,
    parameter int CNT_W      = 16,
    parameter int BR_PENALTY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    input  logic              ex_branch,
    input  logic              ex_taken,
    input  logic [31:0]       ex_target,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    output logic              pc_write,
    output logic              pc_sel_br,
    output logic [31:0]       pc_target,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              busy_flush
);
    // Two bubbles are squashed in the branch cycle itself; only the excess needs FLUSH cycles.
    localparam int SH_W    = $clog2(BR_PENALTY + 1);
    localparam int SH_INIT = (BR_PENALTY > 2) ? (BR_PENALTY - 2) : 1;

    state_t          state, state_nxt;
    logic [SH_W-1:0] sh, sh_nxt;
    logic            taken, load_use;
    logic            stall_inc, flush_inc;

    fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .src          (ex_rs),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .sel          (fwd_a)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .src          (ex_rt),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .sel          (fwd_b)
    );

    assign taken    = ex_branch && ex_taken;
    assign load_use = ex_memread && (ex_rd != '0) &&
                      ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
    assign pc_target = ex_target;

    always_comb begin
        state_nxt  = state;
        sh_nxt     = sh;
        pc_write   = 1'b1;
        pc_sel_br  = 1'b0;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        busy_flush = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        case (state)
            ST_RUN: begin
                if (taken) begin
                    pc_sel_br  = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    flush_inc  = 1'b1;
                    if (BR_PENALTY > 2) begin
                        state_nxt = ST_FLUSH;
                        sh_nxt    = SH_W'(SH_INIT);
                    end
                end else if (load_use) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    stall_inc  = 1'b1;
                end
            end
            ST_FLUSH: begin
                // Branch/load flags here belong to squashed slots and are ignored.
                busy_flush = 1'b1;
                sh_nxt     = sh - 1'b1;
                if (sh == SH_W'(1)) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_RUN;
            sh        <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            sh    <= sh_nxt;
            if (stall_inc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_inc && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (penalty 2 / 16-bit counters, penalty 4 / 4-bit counters).
module tb_pipeline_hazard_ctrl;
    logic        clk, reset;
    logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic        id_uses_rs, id_uses_rt, ex_memread, ex_branch, ex_taken;
    logic        mem_regwrite, wb_regwrite;
    logic [31:0] ex_target;

    logic [1:0]       pw, psel, iw, iflush, xflush, busy;
    logic [1:0][31:0] ptgt;
    logic [1:0][1:0]  fa, fb;
    logic [15:0]      sc_d, fc_d;
    logic [3:0]       sc_s, fc_s;

    int checks = 0;
    int errors = 0;
    int fl_left[2];
    int m_sc[2];
    int m_fc[2];
    int m_pen[2] = '{2, 4};
    int m_max[2] = '{65535, 15};

    pipeline_hazard_ctrl #(.REG_AW(5), .CNT_W(16), .BR_PENALTY(2)) u_d (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_branch(ex_branch), .ex_taken(ex_taken),
        .ex_target(ex_target), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .pc_write(pw[0]), .pc_sel_br(psel[0]),
        .pc_target(ptgt[0]), .ifid_write(iw[0]), .ifid_flush(iflush[0]), .idex_flush(xflush[0]),
        .fwd_a(fa[0]), .fwd_b(fb[0]), .stall_cnt(sc_d), .flush_cnt(fc_d), .busy_flush(busy[0])
    );

    pipeline_hazard_ctrl #(.REG_AW(5), .CNT_W(4), .BR_PENALTY(4)) u_s (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_branch(ex_branch), .ex_taken(ex_taken),
        .ex_target(ex_target), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .pc_write(pw[1]), .pc_sel_br(psel[1]),
        .pc_target(ptgt[1]), .ifid_write(iw[1]), .ifid_flush(iflush[1]), .idex_flush(xflush[1]),
        .fwd_a(fa[1]), .fwd_b(fb[1]), .stall_cnt(sc_s), .flush_cnt(fc_s), .busy_flush(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt, mrd, wrd;
        logic       mrw, wrw;
        logic [1:0] ea, eb;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] r);
        if (mem_regwrite && mem_rd != 0 && mem_rd == r) return 2'd1;
        if (wb_regwrite && wb_rd != 0 && wb_rd == r) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic ref_taken();
        return ex_branch && ex_taken;
    endfunction

    function automatic logic ref_lu();
        return ex_memread && ex_rd != 0 &&
               ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            fl_left[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            logic e_pw, e_ps, e_iw, e_if, e_xf, e_bz;
            string nm;
            nm = $sformatf("%s/dut%0d", tag, i);
            e_pw = 1; e_ps = 0; e_iw = 1; e_if = 0; e_xf = 0; e_bz = 0;
            if (fl_left[i] > 0) e_bz = 1;
            else if (ref_taken()) begin e_ps = 1; e_if = 1; e_xf = 1; end
            else if (ref_lu()) begin e_pw = 0; e_iw = 0; e_xf = 1; end
            chk({nm, "/pc_write"}, 32'(pw[i]), 32'(e_pw));
            chk({nm, "/pc_sel_br"}, 32'(psel[i]), 32'(e_ps));
            chk({nm, "/pc_target"}, ptgt[i], ex_target);
            chk({nm, "/ifid_write"}, 32'(iw[i]), 32'(e_iw));
            chk({nm, "/ifid_flush"}, 32'(iflush[i]), 32'(e_if));
            chk({nm, "/idex_flush"}, 32'(xflush[i]), 32'(e_xf));
            chk({nm, "/busy_flush"}, 32'(busy[i]), 32'(e_bz));
            chk({nm, "/fwd_a"}, 32'(fa[i]), 32'(ref_fwd(ex_rs)));
            chk({nm, "/fwd_b"}, 32'(fb[i]), 32'(ref_fwd(ex_rt)));
            chk({nm, "/stall_cnt"}, (i == 0) ? 32'(sc_d) : 32'(sc_s), 32'(m_sc[i]));
            chk({nm, "/flush_cnt"}, (i == 0) ? 32'(fc_d) : 32'(fc_s), 32'(m_fc[i]));
        end
    endtask

    task automatic model_tick();
        logic tk, lu;
        tk = ref_taken();
        lu = ref_lu();
        for (int i = 0; i < 2; i++) begin
            if (fl_left[i] > 0) fl_left[i]--;
            else if (tk) begin
                if (m_fc[i] < m_max[i]) m_fc[i]++;
                fl_left[i] = (m_pen[i] > 2) ? m_pen[i] - 2 : 0;
            end else if (lu) begin
                if (m_sc[i] < m_max[i]) m_sc[i]++;
            end
        end
    endtask

    // Inputs are already applied; settle, compare with the model, then clock.
    task automatic step(input string tag);
        #1;
        check_all(tag);
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_memread = 0;
        ex_branch = 0; ex_taken = 0; ex_target = 0;
        mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0;
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        vec_t vt[7];
        vt[0] = '{rs: 9,  rt: 3,  mrd: 9, wrd: 9,  mrw: 1, wrw: 1, ea: 1, eb: 0};
        vt[1] = '{rs: 9,  rt: 9,  mrd: 9, wrd: 9,  mrw: 0, wrw: 1, ea: 2, eb: 2};
        vt[2] = '{rs: 0,  rt: 0,  mrd: 0, wrd: 0,  mrw: 1, wrw: 1, ea: 0, eb: 0};
        vt[3] = '{rs: 5,  rt: 7,  mrd: 7, wrd: 5,  mrw: 1, wrw: 1, ea: 2, eb: 1};
        vt[4] = '{rs: 5,  rt: 5,  mrd: 5, wrd: 5,  mrw: 1, wrw: 0, ea: 1, eb: 1};
        vt[5] = '{rs: 12, rt: 31, mrd: 4, wrd: 31, mrw: 1, wrw: 1, ea: 0, eb: 2};
        vt[6] = '{rs: 12, rt: 31, mrd: 4, wrd: 31, mrw: 1, wrw: 0, ea: 0, eb: 0};

        idle();
        reset = 1'b0;
        #1;
        pulse_reset("reset");
        @(posedge clk);
        #1;

        foreach (vt[k]) begin
            ex_rs = vt[k].rs; ex_rt = vt[k].rt; mem_rd = vt[k].mrd; wb_rd = vt[k].wrd;
            mem_regwrite = vt[k].mrw; wb_regwrite = vt[k].wrw;
            #1;
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("vec%0d/dut%0d/fwd_a", k, i), 32'(fa[i]), 32'(vt[k].ea));
                chk($sformatf("vec%0d/dut%0d/fwd_b", k, i), 32'(fb[i]), 32'(vt[k].eb));
            end
            step($sformatf("vec%0d", k));
        end

        // Load-use: one bubble, then counter shows 1; no stall when rs is unused.
        idle();
        ex_memread = 1; ex_rd = 10; id_rs = 10; id_uses_rs = 1;
        #1;
        chk("lu/pc_write", 32'(pw[0]), 0);
        chk("lu/ifid_write", 32'(iw[0]), 0);
        chk("lu/idex_flush", 32'(xflush[0]), 1);
        step("lu");
        id_uses_rs = 0;
        #1;
        chk("lu_after/stall_cnt", 32'(sc_d), 1);
        chk("lu_unused/pc_write", 32'(pw[0]), 1);
        chk("lu_unused/idex_flush", 32'(xflush[0]), 0);
        step("lu_unused");

        // Not-taken then taken branch.
        pulse_reset("reset2");
        idle();
        ex_branch = 1; ex_taken = 0; ex_target = 32'h40;
        #1;
        chk("nt/ifid_flush", 32'(iflush[0]), 0);
        chk("nt/pc_sel_br", 32'(psel[0]), 0);
        step("nt");
        ex_taken = 1;
        #1;
        chk("nt_after/flush_cnt", 32'(fc_d), 0);
        chk("beq/pc_sel_br", 32'(psel[0]), 1);
        chk("beq/pc_target", ptgt[0], 32'h40);
        chk("beq/ifid_flush", 32'(iflush[0]), 1);
        chk("beq/idex_flush", 32'(xflush[0]), 1);
        step("beq");
        idle();
        #1;
        chk("beq_after/flush_cnt", 32'(fc_d), 1);
        chk("beq_after/ifid_flush", 32'(iflush[0]), 0);
        step("beq_after");

        // Branch and load-use together, then a FLUSH window with a spurious branch.
        pulse_reset("reset3");
        idle();
        ex_branch = 1; ex_taken = 1; ex_target = 32'h100;
        ex_memread = 1; ex_rd = 6; id_rt = 6; id_uses_rt = 1;
        #1;
        chk("br_lu/pc_write", 32'(pw[1]), 1);
        chk("br_lu/pc_sel_br", 32'(psel[1]), 1);
        step("br_lu");
        ex_target = 32'h80;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk($sformatf("win%0d/busy_flush", c), 32'(busy[1]), 1);
            chk($sformatf("win%0d/pc_sel_br", c), 32'(psel[1]), 0);
            chk($sformatf("win%0d/idex_flush", c), 32'(xflush[1]), 0);
            step($sformatf("win%0d", c));
        end
        idle();
        #1;
        chk("win_end/busy_flush", 32'(busy[1]), 0);
        chk("win_end/flush_cnt", 32'(fc_s), 1);
        chk("win_end/stall_cnt", 32'(sc_s), 0);
        step("win_end");

        // Reset while in FLUSH takes effect without a clock edge.
        ex_branch = 1; ex_taken = 1; ex_target = 32'h200;
        step("pre_rst");
        idle();
        #1;
        chk("pre_rst/busy_flush", 32'(busy[1]), 1);
        pulse_reset("mid_rst");
        chk("mid_rst/busy_flush", 32'(busy[1]), 0);
        chk("mid_rst/flush_cnt", 32'(fc_s), 0);
        step("post_rst");

        // Saturation of the 4-bit counter.
        idle();
        ex_memread = 1; ex_rd = 3; id_rs = 3; id_uses_rs = 1;
        for (int c = 0; c < 20; c++) step("sat");
        idle();
        #1;
        chk("sat/stall_cnt_4b", 32'(sc_s), 32'hF);
        chk("sat/stall_cnt_16b", 32'(sc_d), 20);
        step("sat_end");

        // Randomized traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
            ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
            ex_rd = 5'($urandom_range(0, 3));
            ex_memread = ($urandom_range(0, 2) == 0);
            ex_branch = ($urandom_range(0, 3) == 0);
            ex_taken = 1'($urandom);
            ex_target = $urandom;
            mem_rd = 5'($urandom_range(0, 3)); mem_regwrite = 1'($urandom);
            wb_rd = 5'($urandom_range(0, 3)); wb_regwrite = 1'($urandom);
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
